// File: rtl/hsv2rgb_pipe.sv
// -----------------------------------------------------------------------------
// hsv2rgb_pipe
//   Fully pipelined HSV to 8-bit RGB converter for the video output path.
//   It takes one pixel per clock with no backpressure and has a fixed
//   five-clock latency. The sideband sync bus and the pixel qualifier are
//   delayed in lockstep with the colour data.
//
//   Arithmetic (all unsigned, bit-exact):
//     sector = floor(h/60), f = h - 60*sector   (h >= 360 treated as 0)
//     fq = sat2047((S*f*1092      + 32768) >> 16)
//     ft = sat2047((S*(60-f)*1092 + 32768) >> 16)
//     p  = (V*(2048-S)  + 1024) >> 11
//     q  = (V*(2048-fq) + 1024) >> 11
//     t  = (V*(2048-ft) + 1024) >> 11
//
// Ports
//   clk        pixel clock
//   reset_b    asynchronous active-low reset, clears every pipeline register
//   in_valid   pixel qualifier
//   in_h       hue 0..359 (larger values are treated as 0)
//   in_s       saturation S/2048, 0..2047
//   in_v       value 0..255
//   in_sync    sideband bus, sampled every clock
//   out_valid  in_valid delayed LATENCY clocks
//   out_r/g/b  RGB result, qualified by out_valid
//   out_sync   in_sync delayed LATENCY clocks
//
// Parameters
//   SYNC_W     sideband bus width
//   LATENCY    in-to-out latency; the colour datapath is built as exactly
//              five register stages, so only 5 is a supported value
// -----------------------------------------------------------------------------
module hsv2rgb_pipe #(
  parameter int SYNC_W  = 3,
  parameter int LATENCY = 5
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              in_valid,
  input  logic [8:0]        in_h,
  input  logic [10:0]       in_s,
  input  logic [7:0]        in_v,
  input  logic [SYNC_W-1:0] in_sync,
  output logic              out_valid,
  output logic [7:0]        out_r,
  output logic [7:0]        out_g,
  output logic [7:0]        out_b,
  output logic [SYNC_W-1:0] out_sync
);

  // Round a Q16 fraction product and clamp it to the 11-bit saturation range.
  function automatic logic [10:0] round_sat_frac(input logic [27:0] prod);
    logic [28:0] sh;
    sh = ({1'b0, prod} + 29'd32768) >> 16;
    if (sh > 29'd2047) round_sat_frac = 11'd2047;
    else               round_sat_frac = sh[10:0];
  endfunction

  // Round a Q11 pixel product to 8 bits. Results never exceed 255 for legal
  // inputs; the clamp only guards against an out-of-range intermediate.
  function automatic logic [7:0] round_px(input logic [19:0] prod);
    logic [20:0] sh;
    sh = ({1'b0, prod} + 21'd1024) >> 11;
    if (sh > 21'd255) round_px = 8'd255;
    else              round_px = sh[7:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Input decode: hue clamp and sector / intra-sector offset
  // ---------------------------------------------------------------------------
  logic [8:0] w_hc;
  logic [2:0] w_sector;
  logic [5:0] w_f;

  always_comb begin
    w_hc     = (in_h >= 9'd360) ? 9'd0 : in_h;
    w_sector = 3'd0;
    w_f      = 6'd0;
    if (w_hc >= 9'd300) begin
      w_sector = 3'd5;
      w_f      = 6'(w_hc - 9'd300);
    end else if (w_hc >= 9'd240) begin
      w_sector = 3'd4;
      w_f      = 6'(w_hc - 9'd240);
    end else if (w_hc >= 9'd180) begin
      w_sector = 3'd3;
      w_f      = 6'(w_hc - 9'd180);
    end else if (w_hc >= 9'd120) begin
      w_sector = 3'd2;
      w_f      = 6'(w_hc - 9'd120);
    end else if (w_hc >= 9'd60) begin
      w_sector = 3'd1;
      w_f      = 6'(w_hc - 9'd60);
    end else begin
      w_sector = 3'd0;
      w_f      = 6'(w_hc);
    end
  end

  // Pipeline registers
  logic [2:0]  r_sector_p0, r_sector_p1, r_sector_p2, r_sector_p3;
  logic [5:0]  r_f_p0;
  logic [10:0] r_s_p0;
  logic [7:0]  r_v_p0, r_v_p1, r_v_p2, r_v_p3;
  logic [16:0] r_sf_p1, r_sft_p1;
  logic [11:0] r_sinv_p1;
  logic [27:0] r_fqm_p2, r_ftm_p2;
  logic [19:0] r_pm_p2;
  logic [19:0] r_qm_p3, r_tm_p3;
  logic [7:0]  r_p_p3;
  logic [7:0]  r_r_p4, r_g_p4, r_b_p4;

  // Combinational helpers between stages
  logic [5:0]  w_fc_p0;
  logic [10:0] w_fq_p2, w_ft_p2;
  logic [11:0] w_qinv_p2, w_tinv_p2;
  logic [7:0]  w_q_p3, w_t_p3;
  logic [7:0]  w_r_p3, w_g_p3, w_b_p3;

  assign w_fc_p0   = 6'd60 - r_f_p0;
  assign w_fq_p2   = round_sat_frac(r_fqm_p2);
  assign w_ft_p2   = round_sat_frac(r_ftm_p2);
  assign w_qinv_p2 = 12'd2048 - {1'b0, w_fq_p2};
  assign w_tinv_p2 = 12'd2048 - {1'b0, w_ft_p2};
  assign w_q_p3    = round_px(r_qm_p3);
  assign w_t_p3    = round_px(r_tm_p3);

  // Sector to channel routing
  always_comb begin
    w_r_p3 = r_v_p3;
    w_g_p3 = r_v_p3;
    w_b_p3 = r_v_p3;
    case (r_sector_p3)
      3'd0: begin w_r_p3 = r_v_p3; w_g_p3 = w_t_p3; w_b_p3 = r_p_p3; end
      3'd1: begin w_r_p3 = w_q_p3; w_g_p3 = r_v_p3; w_b_p3 = r_p_p3; end
      3'd2: begin w_r_p3 = r_p_p3; w_g_p3 = r_v_p3; w_b_p3 = w_t_p3; end
      3'd3: begin w_r_p3 = r_p_p3; w_g_p3 = w_q_p3; w_b_p3 = r_v_p3; end
      3'd4: begin w_r_p3 = w_t_p3; w_g_p3 = r_p_p3; w_b_p3 = r_v_p3; end
      3'd5: begin w_r_p3 = r_v_p3; w_g_p3 = r_p_p3; w_b_p3 = w_q_p3; end
      default: begin w_r_p3 = r_v_p3; w_g_p3 = r_v_p3; w_b_p3 = r_v_p3; end
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_sector_p0 <= '0;
      r_f_p0      <= '0;
      r_s_p0      <= '0;
      r_v_p0      <= '0;
      r_sector_p1 <= '0;
      r_v_p1      <= '0;
      r_sf_p1     <= '0;
      r_sft_p1    <= '0;
      r_sinv_p1   <= '0;
      r_sector_p2 <= '0;
      r_v_p2      <= '0;
      r_fqm_p2    <= '0;
      r_ftm_p2    <= '0;
      r_pm_p2     <= '0;
      r_sector_p3 <= '0;
      r_v_p3      <= '0;
      r_qm_p3     <= '0;
      r_tm_p3     <= '0;
      r_p_p3      <= '0;
      r_r_p4      <= '0;
      r_g_p4      <= '0;
      r_b_p4      <= '0;
    end else begin
      // ---- stage 0: register decoded hue and raw S/V ----
      r_sector_p0 <= w_sector;
      r_f_p0      <= w_f;
      r_s_p0      <= in_s;
      r_v_p0      <= in_v;
      // ---- stage 1: S*f, S*(60-f) and 2048-S ----
      r_sector_p1 <= r_sector_p0;
      r_v_p1      <= r_v_p0;
      r_sf_p1     <= {6'd0, r_s_p0} * {11'd0, r_f_p0};
      r_sft_p1    <= {6'd0, r_s_p0} * {11'd0, w_fc_p0};
      r_sinv_p1   <= 12'd2048 - {1'b0, r_s_p0};
      // ---- stage 2: scale by 1092 (~65536/60) and form V*(2048-S) ----
      r_sector_p2 <= r_sector_p1;
      r_v_p2      <= r_v_p1;
      r_fqm_p2    <= {11'd0, r_sf_p1} * 28'd1092;
      r_ftm_p2    <= {11'd0, r_sft_p1} * 28'd1092;
      r_pm_p2     <= {12'd0, r_v_p1} * {8'd0, r_sinv_p1};
      // ---- stage 3: V*(2048-fq), V*(2048-ft), round p ----
      r_sector_p3 <= r_sector_p2;
      r_v_p3      <= r_v_p2;
      r_qm_p3     <= {12'd0, r_v_p2} * {8'd0, w_qinv_p2};
      r_tm_p3     <= {12'd0, r_v_p2} * {8'd0, w_tinv_p2};
      r_p_p3      <= round_px(r_pm_p2);
      // ---- stage 4: round q/t and route to RGB ----
      r_r_p4      <= w_r_p3;
      r_g_p4      <= w_g_p3;
      r_b_p4      <= w_b_p3;
    end
  end

  // Qualifier and sideband delay line; entry i lines up with stage _p<i>.
  logic              r_vld_pipe  [LATENCY];
  logic [SYNC_W-1:0] r_sync_pipe [LATENCY];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_vld_pipe[i]  <= 1'b0;
        r_sync_pipe[i] <= '0;
      end
    end else begin
      r_vld_pipe[0]  <= in_valid;
      r_sync_pipe[0] <= in_sync;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1];
        r_sync_pipe[i] <= r_sync_pipe[i-1];
      end
    end
  end

  assign out_valid = r_vld_pipe[LATENCY-1];
  assign out_sync  = r_sync_pipe[LATENCY-1];
  assign out_r     = r_r_p4;
  assign out_g     = r_g_p4;
  assign out_b     = r_b_p4;

endmodule

// File: tb/tb_hsv2rgb_pipe.sv
// -----------------------------------------------------------------------------
// tb_hsv2rgb_pipe
//   Self-checking bench for hsv2rgb_pipe. Every driven clock pushes the
//   expected output (qualifier, sideband and RGB) into a queue; each clock
//   after the DUT latency pops one entry and compares it with the outputs.
// -----------------------------------------------------------------------------
module tb_hsv2rgb_pipe;

  localparam int SYNC_W = 3;
  localparam int LAT    = 5;

  logic              clk      = 1'b0;
  logic              reset_b  = 1'b1;
  logic              in_valid = 1'b0;
  logic [8:0]        in_h     = '0;
  logic [10:0]       in_s     = '0;
  logic [7:0]        in_v     = '0;
  logic [SYNC_W-1:0] in_sync  = '0;
  logic              out_valid;
  logic [7:0]        out_r, out_g, out_b;
  logic [SYNC_W-1:0] out_sync;

  hsv2rgb_pipe #(.SYNC_W(SYNC_W), .LATENCY(LAT)) dut (
    .clk      (clk),
    .reset_b  (reset_b),
    .in_valid (in_valid),
    .in_h     (in_h),
    .in_s     (in_s),
    .in_v     (in_v),
    .in_sync  (in_sync),
    .out_valid(out_valid),
    .out_r    (out_r),
    .out_g    (out_g),
    .out_b    (out_b),
    .out_sync (out_sync)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              vld;
    logic [SYNC_W-1:0] sync;
    logic              chk_rgb;
    logic [7:0]        r;
    logic [7:0]        g;
    logic [7:0]        b;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Golden model written straight from the conversion formulas.
  function automatic logic [23:0] golden(input int h, input int s, input int v);
    longint hc, sec, f, fq, ft, p, q, t, r, g, b;
    hc  = (h >= 360) ? 0 : h;
    sec = hc / 60;
    f   = hc - 60 * sec;
    fq  = (longint'(s) * f * 1092 + 32768) >>> 16;
    if (fq > 2047) fq = 2047;
    ft  = (longint'(s) * (60 - f) * 1092 + 32768) >>> 16;
    if (ft > 2047) ft = 2047;
    p   = (longint'(v) * (2048 - s)  + 1024) >>> 11;
    q   = (longint'(v) * (2048 - fq) + 1024) >>> 11;
    t   = (longint'(v) * (2048 - ft) + 1024) >>> 11;
    r = v; g = v; b = v;
    case (sec)
      0: begin r = v; g = t; b = p; end
      1: begin r = q; g = v; b = p; end
      2: begin r = p; g = v; b = t; end
      3: begin r = p; g = q; b = v; end
      4: begin r = t; g = p; b = v; end
      default: begin r = v; g = p; b = q; end
    endcase
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  // Drive one clock of input and record what must appear LAT clocks later.
  task automatic drive_px(input logic vld, input int h, input int s, input int v,
                          input logic [SYNC_W-1:0] sy, input logic use_k,
                          input logic [23:0] k);
    exp_t e;
    logic [23:0] rgb;
    @(negedge clk);
    in_valid = vld;
    in_h     = 9'(h);
    in_s     = 11'(s);
    in_v     = 8'(v);
    in_sync  = sy;
    rgb      = use_k ? k : golden(h, s, v);
    e.vld    = vld;
    e.sync   = sy;
    e.chk_rgb = 1'b0;
    {e.r, e.g, e.b} = rgb;
    sb.push_back(e);
  endtask

  // After reset release the pipeline holds zeros for the first LAT-1 outputs.
  task automatic sb_restart();
    exp_t z;
    z.vld = 1'b0; z.sync = '0; z.chk_rgb = 1'b1; z.r = 8'd0; z.g = 8'd0; z.b = 8'd0;
    sb.delete();
    repeat (LAT - 1) sb.push_back(z);
  endtask

  task automatic test_reset();
    #1 reset_b = 1'b0;
    in_valid = 1'b1; in_h = 9'd0; in_s = 11'd2047; in_v = 8'd255; in_sync = '1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_sync, out_r, out_g, out_b} !== '0) begin
        failures++;
        $display("FAIL reset_state: got vld=%b sync=%b rgb=%0d,%0d,%0d, want all zero",
                 out_valid, out_sync, out_r, out_g, out_b);
      end
    end
    #1 reset_b = 1'b1;
    in_valid = 1'b0;
    in_sync  = '0;
    sb_restart();
  endtask

  task automatic test_directed();
    int th[7] = '{0,    60,   240,  30,   120, 400,  200};
    int ts[7] = '{2047, 2047, 2047, 1024, 0,   2047, 1500};
    int tv[7] = '{255,  255,  255,  128,  200, 255,  0};
    logic [23:0] tk[7] = '{{8'd255, 8'd0,   8'd0},   {8'd255, 8'd255, 8'd0},
                           {8'd0,   8'd0,   8'd255}, {8'd128, 8'd96,  8'd64},
                           {8'd200, 8'd200, 8'd200}, {8'd255, 8'd0,   8'd0},
                           {8'd0,   8'd0,   8'd0}};
    exp_t e;
    for (int i = 0; i < 7 + LAT; i++) begin
      if (i < 7) drive_px(1'b1, th[i], ts[i], tv[i], 3'(i + 1), 1'b1, tk[i]);
      else       drive_px(1'b0, 0, 0, 0, 3'd0, 1'b1, 24'd0);
      @(posedge clk); #1;
      if (sb.size() == LAT) begin
        e = sb.pop_front();
        checks++;
        if (out_valid !== e.vld || out_sync !== e.sync) begin
          failures++;
          $display("FAIL directed_ctrl: got vld=%b sync=%b, want vld=%b sync=%b",
                   out_valid, out_sync, e.vld, e.sync);
        end
        if (e.vld || e.chk_rgb) begin
          checks++;
          if ({out_r, out_g, out_b} !== {e.r, e.g, e.b}) begin
            failures++;
            $display("FAIL directed_rgb: got %0d,%0d,%0d, want %0d,%0d,%0d",
                     out_r, out_g, out_b, e.r, e.g, e.b);
          end
        end
      end else begin
        checks++; failures++;
        $display("FAIL directed_align: scoreboard depth %0d, want %0d", sb.size(), LAT);
      end
    end
  endtask

  // S=0 must give grey at V, V=0 must give black, for any hue (incl. clamped).
  task automatic test_special();
    int hues[8] = '{0, 59, 61, 179, 299, 359, 360, 511};
    exp_t e;
    int v, s;
    for (int i = 0; i < 16 + LAT; i++) begin
      if (i < 8) begin
        v = int'($urandom_range(1, 255));
        drive_px(1'b1, hues[i], 0, v, 3'(i), 1'b1, {8'(v), 8'(v), 8'(v)});
      end else if (i < 16) begin
        s = int'($urandom_range(0, 2047));
        drive_px(1'b1, hues[i-8], s, 0, 3'(i), 1'b1, 24'd0);
      end else begin
        drive_px(1'b0, 0, 0, 0, 3'd0, 1'b1, 24'd0);
      end
      @(posedge clk); #1;
      if (sb.size() == LAT) begin
        e = sb.pop_front();
        checks++;
        if (out_valid !== e.vld || out_sync !== e.sync) begin
          failures++;
          $display("FAIL special_ctrl: got vld=%b sync=%b, want vld=%b sync=%b",
                   out_valid, out_sync, e.vld, e.sync);
        end
        if (e.vld || e.chk_rgb) begin
          checks++;
          if ({out_r, out_g, out_b} !== {e.r, e.g, e.b}) begin
            failures++;
            $display("FAIL special_rgb: got %0d,%0d,%0d, want %0d,%0d,%0d",
                     out_r, out_g, out_b, e.r, e.g, e.b);
          end
        end
      end else begin
        checks++; failures++;
        $display("FAIL special_align: scoreboard depth %0d, want %0d", sb.size(), LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic vld;
    for (int i = 0; i < 1000 + LAT; i++) begin
      if (i < 1000) begin
        vld = ($urandom_range(0, 3) != 0);
        drive_px(vld, int'($urandom_range(0, 511)), int'($urandom_range(0, 2047)),
                 int'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'b0, 24'd0);
      end else begin
        drive_px(1'b0, 0, 0, 0, 3'd0, 1'b1, 24'd0);
      end
      @(posedge clk); #1;
      if (sb.size() == LAT) begin
        e = sb.pop_front();
        checks++;
        if (out_valid !== e.vld || out_sync !== e.sync) begin
          failures++;
          $display("FAIL b2b_ctrl: got vld=%b sync=%b, want vld=%b sync=%b",
                   out_valid, out_sync, e.vld, e.sync);
        end
        if (e.vld || e.chk_rgb) begin
          checks++;
          if ({out_r, out_g, out_b} !== {e.r, e.g, e.b}) begin
            failures++;
            $display("FAIL b2b_rgb: got %0d,%0d,%0d, want %0d,%0d,%0d",
                     out_r, out_g, out_b, e.r, e.g, e.b);
          end
        end
      end else begin
        checks++; failures++;
        $display("FAIL b2b_align: scoreboard depth %0d, want %0d", sb.size(), LAT);
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    // Fill the pipe with valid pixels so outputs are live when reset hits.
    for (int i = 0; i < 8; i++) begin
      drive_px(1'b1, 100 + 20 * i, 2000, 250, 3'(i), 1'b0, 24'd0);
      @(posedge clk); #1;
      if (sb.size() == LAT) begin
        e = sb.pop_front();
        checks++;
        if (out_valid !== e.vld || out_sync !== e.sync) begin
          failures++;
          $display("FAIL midrst_pre_ctrl: got vld=%b sync=%b, want vld=%b sync=%b",
                   out_valid, out_sync, e.vld, e.sync);
        end
        if (e.vld || e.chk_rgb) begin
          checks++;
          if ({out_r, out_g, out_b} !== {e.r, e.g, e.b}) begin
            failures++;
            $display("FAIL midrst_pre_rgb: got %0d,%0d,%0d, want %0d,%0d,%0d",
                     out_r, out_g, out_b, e.r, e.g, e.b);
          end
        end
      end else begin
        checks++; failures++;
        $display("FAIL midrst_align: scoreboard depth %0d, want %0d", sb.size(), LAT);
      end
    end
    // Assert between clock edges: outputs must clear without a clock.
    #1 reset_b = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_sync, out_r, out_g, out_b} !== '0) begin
      failures++;
      $display("FAIL midrst_async: got vld=%b sync=%b rgb=%0d,%0d,%0d, want all zero",
               out_valid, out_sync, out_r, out_g, out_b);
    end
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_sync, out_r, out_g, out_b} !== '0) begin
        failures++;
        $display("FAIL midrst_hold: got vld=%b sync=%b rgb=%0d,%0d,%0d, want all zero",
                 out_valid, out_sync, out_r, out_g, out_b);
      end
    end
    #1 reset_b = 1'b1;
    sb_restart();
    // Idle, then a single pixel, then drain.
    for (int i = 0; i < 13; i++) begin
      if (i == 6) drive_px(1'b1, 200, 1800, 240, 3'd5, 1'b0, 24'd0);
      else        drive_px(1'b0, 0, 0, 0, 3'($urandom_range(0, 7)), 1'b0, 24'd0);
      @(posedge clk); #1;
      if (sb.size() == LAT) begin
        e = sb.pop_front();
        checks++;
        if (out_valid !== e.vld || out_sync !== e.sync) begin
          failures++;
          $display("FAIL midrst_post_ctrl: got vld=%b sync=%b, want vld=%b sync=%b",
                   out_valid, out_sync, e.vld, e.sync);
        end
        if (e.vld || e.chk_rgb) begin
          checks++;
          if ({out_r, out_g, out_b} !== {e.r, e.g, e.b}) begin
            failures++;
            $display("FAIL midrst_post_rgb: got %0d,%0d,%0d, want %0d,%0d,%0d",
                     out_r, out_g, out_b, e.r, e.g, e.b);
          end
        end
      end else begin
        checks++; failures++;
        $display("FAIL midrst_post_align: scoreboard depth %0d, want %0d", sb.size(), LAT);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_special();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
